// File: rtl/adder_pkg.sv
// Shared definitions for the balanced adder / subtractor family.
// The default operand width and the pipeline word used by default-width users.
package adder_pkg;

  localparam int ADDER_WIDTH_DEFAULT = 8;

  typedef struct packed {
    logic [ADDER_WIDTH_DEFAULT+1:0] val;
    logic                           vld;
  } pipe_word_t;

endpackage

// File: rtl/pipe_reg_stage.sv
// Valid/ready register slice: loads whenever it is empty or its consumer takes the
// current word, so a full chain of slices shifts by one with no bubble.
module pipe_reg_stage #(
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data
);

  logic          r_valid;
  logic [DW-1:0] r_data;
  logic          w_adv;

  assign w_adv = !r_valid || i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_adv) begin
      r_valid <= i_valid;
      r_data  <= i_data;
    end
  end

  assign o_ready = w_adv;
  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/balanced_subtractor.sv
// Two-stage subtractor recovering c = sum - a - b behind the balanced adder:
// stage 1 forms sum - a (carrying b along), stage 2 subtracts b.
module balanced_subtractor
  import adder_pkg::*;
#(
  parameter int WIDTH    = ADDER_WIDTH_DEFAULT,
  parameter bit SATURATE = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_sum,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
);

  typedef struct packed {
    logic [WIDTH+1:0] val;
    logic             vld;
  } stage_word_t;

  logic [WIDTH:0]     w_d1_next;
  logic [2*WIDTH:0]   w_s1_in;
  logic [2*WIDTH:0]   w_s1_out;
  logic               w_v1;
  logic [WIDTH:0]     w_d1;
  logic [WIDTH-1:0]   w_b1;
  logic [WIDTH+1:0]   w_r_next;
  logic               w_s2_ready;
  logic [WIDTH+1:0]   w_r;
  logic               w_v2;
  stage_word_t        w_out;
  logic               w_unused_msb;

  // Stage 1 keeps sum - a as a WIDTH+1 value whose MSB is the first borrow.
  assign w_d1_next = {1'b0, i_sum} - {1'b0, i_a};
  assign w_s1_in   = {i_b, w_d1_next};

  pipe_reg_stage #(.DW(2*WIDTH+1)) u_stage1 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (w_s1_in),
    .o_valid (w_v1),
    .i_ready (w_s2_ready),
    .o_data  (w_s1_out)
  );

  assign w_d1 = w_s1_out[WIDTH:0];
  assign w_b1 = w_s1_out[2*WIDTH:WIDTH+1];

  // Sign-extending d1 keeps the worst case (0 - max - max) representable.
  assign w_r_next = {w_d1[WIDTH], w_d1} - {2'b00, w_b1};

  pipe_reg_stage #(.DW(WIDTH+2)) u_stage2 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (w_v1),
    .o_ready (w_s2_ready),
    .i_data  (w_r_next),
    .o_valid (w_v2),
    .i_ready (i_ready),
    .o_data  (w_r)
  );

  assign w_out        = '{val: w_r, vld: w_v2};
  assign w_unused_msb = w_out.val[WIDTH];

  assign o_valid  = w_out.vld;
  assign o_borrow = w_out.val[WIDTH+1];
  assign o_diff   = (SATURATE && o_borrow) ? '0 : w_out.val[WIDTH-1:0];

endmodule
